dock_cfg_sequencer: RTL
=======================

Name: dock_cfg_sequencer

Overview:
- Initiator side of the Dock address-decoder configuration bus: drives cfg_we/cfg_addr/cfg_wdata into the decoder's window tables.
- Accepts whole window descriptors (index, base, mask, slot, op) over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each descriptor into four single-cycle register writes, with done/error status.
- Sits between the host-side configuration agent (boot ROM loader / management MCU bridge) and the decoder's cfg port.

Parameters:
- NUM_WIN, 4, number of decoder windows; register stride between tables.
- WIN_IDX_W, 4, width of the descriptor window index.
- FIFO_AW, 2, log2 of descriptor FIFO depth (default depth 4).
- ADDR_W, 8, decoder address width; only 8 is supported (one cfg byte per table entry).

Ports:
- cfg_clk  in  1  configuration clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-high.
- desc_valid  in  1  descriptor offered.
- desc_ready  out  1  FIFO can accept; equals !full.
- desc_win  in  WIN_IDX_W  target window index.
- desc_base  in  8  window base.
- desc_mask  in  8  window mask.
- desc_slot  in  8  target slot.
- desc_op  in  8  op code (0x00 write-only, 0x01 read-only, 0xFF any).
- cfg_we  out  1  decoder write strobe.
- cfg_addr  out  8  decoder register address.
- cfg_wdata  out  8  decoder write data.
- busy  out  1  FIFO non-empty or sequence in flight.
- done  out  1  one-cycle pulse per completed descriptor.
- err_range  out  1  one-cycle pulse when a descriptor is dropped for desc_win >= NUM_WIN.

Behaviour:
- Reset (rst_n=1, async): FSM to IDLE, FIFO pointers and count cleared, buffered descriptors discarded. cfg_we=0, cfg_addr=0, cfg_wdata=0, done=0, err_range=0, busy=0, desc_ready=0 while reset is held. desc_ready=1 on the first cycle after release.
- Push: a descriptor is pushed on a cycle with desc_valid & desc_ready. desc_ready is derived from the registered count, so a push and pop on the same cycle when full is impossible (desc_ready=0).
- Pop: a push and pop on the same cycle when neither full nor empty leaves the count unchanged.
- FSM states: IDLE -> W_BASE -> W_MASK -> W_SLOT -> W_OP -> IDLE.
- IDLE: if the FIFO is non-empty, pop the head into a holding register.
  - If win < NUM_WIN: go to W_BASE next cycle.
  - Otherwise: pulse err_range next cycle, no cfg_we, stay in IDLE.
- Each W_* state lasts exactly one cycle, with cfg_we=1 and cfg_addr/cfg_wdata registered:
  - W_BASE: addr=win, data=base.
  - W_MASK: addr=NUM_WIN+win, data=mask.
  - W_SLOT: addr=2*NUM_WIN+win, data=slot.
  - W_OP: addr=3*NUM_WIN+win, data=op.
- Addresses are computed in 8 bits; there is no wrap because NUM_WIN*4 <= 256 is required.
- In IDLE, cfg_we=0 and cfg_addr/cfg_wdata hold their last values.
- Timing:
  - done pulses in the cycle after W_OP, which is the first IDLE cycle.
  - Pop-to-first-write latency is 1 cycle.
  - Back-to-back descriptors spend one IDLE cycle between sequences (5 cycles per descriptor).
- busy=1 whenever count != 0 or the FSM is not in IDLE.
- Reset mid-sequence: cfg_we drops asynchronously, and the partial window is not completed.

Optional Feature:
- Macro: DOCK_CFG_READBACK_EN.
- When defined, the block adds:
  - Ports cfg_re (out, 1), cfg_rdata (in, 8) and err_verify (out, 1, sticky).
  - States R_BASE, R_MASK, R_SLOT, R_OP, R_LAST after W_OP.
- Read-back sequence:
  - Each R_* state drives cfg_re=1 for one cycle with cfg_addr equal to the corresponding write address.
  - cfg_rdata is sampled one cycle later and compared with the written byte; the last compare happens in R_LAST.
  - Any mismatch sets err_verify, which clears only on reset.
  - done pulses after the final compare, so each descriptor takes 10 cycles.
- When not defined: cfg_re, cfg_rdata and err_verify do not exist, and the FSM goes W_OP -> IDLE.

Test Plan:
- Single descriptor (NUM_WIN=4): win=1, base=0x20, mask=0xF0, slot=0x01, op=0x00 -> four consecutive cfg_we cycles (0x01,0x20), (0x05,0xF0), (0x09,0x01), (0x0D,0x00), then one done pulse; busy high throughout.
- Three descriptors for windows 0/2/3 pushed back-to-back:
  - desc_ready stays 1.
  - Writes hit 0x00/0x04/0x08/0x0C, then 0x02..0x0E, then 0x03..0x0F, in order.
  - Exactly 5 cycles between the first cfg_we of successive descriptors; 3 done pulses.
- FIFO full (FIFO_AW=2): 6 pushes while the first is in flight -> desc_ready falls after 5 accepted descriptors; the 6th stays stalled until the next pop; nothing is lost.
- Out-of-range: desc_win=4 -> err_range pulses once, no cfg_we, no done; a following valid descriptor proceeds normally.
- Reset mid-sequence: assert rst_n during W_MASK with 2 descriptors queued -> cfg_we=0 immediately, busy=0; after release no further writes occur.
- DOCK_CFG_READBACK_EN: a model returns 0xF1 for addr 0x05 -> err_verify=1 after R_LAST compare and stays 1; done still pulses.

Source files
------------

// File: rtl/dock_cfg_sequencer.sv
// dock_cfg_sequencer: queues Dock window descriptors and writes each one into
// the decoder window tables as four single-byte cfg writes.
// Ports: cfg_clk, rst_n (async, active-high);
//   desc_valid/desc_ready + desc_win/base/mask/slot/op (descriptor in);
//   cfg_we/cfg_addr/cfg_wdata (decoder cfg port);
//   busy, done (per descriptor), err_range (dropped descriptor).
// Build option DOCK_CFG_READBACK_EN adds cfg_re, cfg_rdata and a sticky
// err_verify, reading each table entry back after it is written.
module dock_cfg_sequencer #(
  parameter int NUM_WIN   = 4,
  parameter int WIN_IDX_W = 4,
  parameter int FIFO_AW   = 2,
  parameter int ADDR_W    = 8
) (
  input  logic                 cfg_clk,
  input  logic                 rst_n,
  input  logic                 desc_valid,
  output logic                 desc_ready,
  input  logic [WIN_IDX_W-1:0] desc_win,
  input  logic [7:0]           desc_base,
  input  logic [7:0]           desc_mask,
  input  logic [7:0]           desc_slot,
  input  logic [7:0]           desc_op,
  output logic                 cfg_we,
  output logic [ADDR_W-1:0]    cfg_addr,
  output logic [7:0]           cfg_wdata,
`ifdef DOCK_CFG_READBACK_EN
  output logic                 cfg_re,
  input  logic [7:0]           cfg_rdata,
  output logic                 err_verify,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 err_range
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW+1)'(1);

  typedef struct packed {
    logic [WIN_IDX_W-1:0] win;
    logic [7:0]           base;
    logic [7:0]           mask;
    logic [7:0]           slot;
    logic [7:0]           op;
  } desc_t;

  typedef enum logic [3:0] {
    IDLE, W_BASE, W_MASK, W_SLOT, W_OP
`ifdef DOCK_CFG_READBACK_EN
    , R_BASE, R_MASK, R_SLOT, R_OP, R_LAST
`endif
  } state_t;

  desc_t              mem [DEPTH];
  desc_t              din;
  desc_t              head;
  desc_t              hold;
  state_t             state;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               push;
  logic               pop;
  logic               in_range;

  // Table k of the decoder starts at k*NUM_WIN.
  function automatic logic [ADDR_W-1:0] waddr(
    input logic [WIN_IDX_W-1:0] w,
    input logic [1:0]           k
  );
    waddr = ADDR_W'(k) * ADDR_W'(NUM_WIN) + ADDR_W'(w);
  endfunction

  function automatic logic [7:0] field(
    input desc_t      d,
    input logic [1:0] k
  );
    case (k)
      2'd0:    field = d.base;
      2'd1:    field = d.mask;
      2'd2:    field = d.slot;
      default: field = d.op;
    endcase
  endfunction

  assign din        = {desc_win, desc_base, desc_mask, desc_slot, desc_op};
  assign head       = mem[rd_ptr];
  // count[MSB] is set only at full depth
  assign desc_ready = !count[FIFO_AW] && !rst_n;
  assign push       = desc_valid && desc_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign in_range   = 32'(head.win) < 32'(NUM_WIN);
  assign busy       = (count != '0) || (state != IDLE);

  always_ff @(posedge cfg_clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge cfg_clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge cfg_clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      hold       <= '0;
      cfg_we     <= 1'b0;
      cfg_addr   <= '0;
      cfg_wdata  <= '0;
      done       <= 1'b0;
      err_range  <= 1'b0;
`ifdef DOCK_CFG_READBACK_EN
      cfg_re     <= 1'b0;
      err_verify <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      err_range <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            hold <= head;
            if (in_range) begin
              state     <= W_BASE;
              cfg_we    <= 1'b1;
              cfg_addr  <= waddr(head.win, 2'd0);
              cfg_wdata <= field(head, 2'd0);
            end else begin
              err_range <= 1'b1;
            end
          end
        end
        W_BASE: begin
          state     <= W_MASK;
          cfg_addr  <= waddr(hold.win, 2'd1);
          cfg_wdata <= field(hold, 2'd1);
        end
        W_MASK: begin
          state     <= W_SLOT;
          cfg_addr  <= waddr(hold.win, 2'd2);
          cfg_wdata <= field(hold, 2'd2);
        end
        W_SLOT: begin
          state     <= W_OP;
          cfg_addr  <= waddr(hold.win, 2'd3);
          cfg_wdata <= field(hold, 2'd3);
        end
`ifdef DOCK_CFG_READBACK_EN
        W_OP: begin
          state    <= R_BASE;
          cfg_we   <= 1'b0;
          cfg_re   <= 1'b1;
          cfg_addr <= waddr(hold.win, 2'd0);
        end
        // read data lags the read address by one cycle
        R_BASE: begin
          state    <= R_MASK;
          cfg_addr <= waddr(hold.win, 2'd1);
        end
        R_MASK: begin
          state    <= R_SLOT;
          cfg_addr <= waddr(hold.win, 2'd2);
          if (cfg_rdata != field(hold, 2'd0)) err_verify <= 1'b1;
        end
        R_SLOT: begin
          state    <= R_OP;
          cfg_addr <= waddr(hold.win, 2'd3);
          if (cfg_rdata != field(hold, 2'd1)) err_verify <= 1'b1;
        end
        R_OP: begin
          state  <= R_LAST;
          cfg_re <= 1'b0;
          if (cfg_rdata != field(hold, 2'd2)) err_verify <= 1'b1;
        end
        R_LAST: begin
          state <= IDLE;
          done  <= 1'b1;
          if (cfg_rdata != field(hold, 2'd3)) err_verify <= 1'b1;
        end
`else
        W_OP: begin
          state  <= IDLE;
          cfg_we <= 1'b0;
          done   <= 1'b1;
        end
`endif
        default: begin
          state  <= IDLE;
          cfg_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
